my_counter_n: RTL
=================

MY_COUNTER_N -- requirements
Module: my_counter_n

Interface
REQ-001 SHALL have parameter WIDTH, default 4: bit width of D and Q; legal range 2..16.
REQ-002 SHALL have parameter MODULUS, default 16: count length; legal range 2..2**WIDTH; elaboration error outside range.
REQ-003 SHALL have port CP, input, 1: the single clock; all state updates on rising edge.
REQ-004 SHALL have port CR, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port LDbar, input, 1: synchronous parallel load, active-low.
REQ-006 SHALL have port CTP, input, 1: count enable (parallel).
REQ-007 SHALL have port CTT, input, 1: count enable (trickle); also gates CO.
REQ-008 SHALL have port UD, input, 1: direction; 1 = up, 0 = down.
REQ-009 SHALL have port D, input, WIDTH: load data.
REQ-010 SHALL have port Q, output, WIDTH: registered count.
REQ-011 SHALL have port CO, output, 1: combinational terminal-count carry for cascading.

Function
REQ-012 SHALL apply, per rising CP edge, priority CR > load (LDbar=0) > count (CTP=1 and CTT=1) > hold.
REQ-013 SHALL, on load, set Q to D verbatim (no clamping), independent of CTP/CTT/UD.
REQ-014 SHALL, on up-count, set Q to 0 when Q >= MODULUS-1, else Q+1.
REQ-015 SHALL, on down-count, set Q to MODULUS-1 when Q == 0 or Q > MODULUS-1, else Q-1.
REQ-016 SHALL hold Q when either CTP=0 or CTT=0 and no reset/load.
REQ-017 SHALL drive CO = CTT and (UD ? Q == MODULUS-1 : Q == 0); CO independent of CTP, CR, LDbar.
REQ-018 SHALL make count latency one CP edge; CO follows Q combinationally with zero added cycles.
REQ-019 SHALL allow UD to change on any cycle; the new direction takes effect on the next edge; no internal direction state.
REQ-020 SHALL, when MODULUS == 2**WIDTH, wrap naturally (0xF+1 -> 0, 0-1 -> 0xF for WIDTH=4).

Reset
REQ-021 SHALL set Q to 0 on any rising CP edge with CR=1, overriding simultaneous load and count.
REQ-022 SHALL produce CO = CTT and UD-dependent decode of Q=0 after reset (CO=1 if CTT=1 and UD=0).
REQ-023 SHALL have no asynchronous reset path; Q is undefined before the first edge with CR=1.

Configuration
REQ-024 SHALL honour macro MY_COUNTER_DOWN_EN: defined -> UD behaves per REQ-015/017; undefined -> UD port remains but is ignored, counter is up-only, CO decodes Q == MODULUS-1 only.

Structure
REQ-025 SHALL place direction constants (DIR_UP=1, DIR_DOWN=0) and a MODULUS legality check function in shared package my_counter_pkg.
REQ-026 SHALL implement the terminal-count decode (Q, UD, CTT -> CO, wrap flag) as sub-module my_counter_tc, reused by the next-state logic.

Verification
REQ-027 SHALL cover: WIDTH=4, MODULUS=16, CR=1 one edge, then CTP=CTT=1, UD=1 for 17 edges -> Q 0..15 then 0; CO=1 exactly while Q=15.
REQ-028 SHALL cover: MODULUS=10, UD=1, counting from 0 -> Q 0..9 then 0; CO=1 at Q=9; with UD=0 from 0 -> 9, 8, ..., 0, 9.
REQ-029 SHALL cover: LDbar=0, D=4'b1100, CTP=CTT=1 -> Q=12 next edge; then LDbar=1, MODULUS=10, UD=1 -> Q=0; UD=0 from 12 -> Q=9.
REQ-030 SHALL cover: CR=1 and LDbar=0 and count asserted on the same edge -> Q=0; CR mid-count at Q=7 -> Q=0 next edge.
REQ-031 SHALL cover: CTT=0, CTP=1 at Q=15, UD=1 -> Q holds 15, CO=0; CTT=1, CTP=0 -> Q holds, CO=1.
REQ-032 SHALL cover: two instances cascaded (low CO -> high CTT), WIDTH=4 each, MODULUS=16 -> combined count 0x0F -> 0x10 in one edge; with MY_COUNTER_DOWN_EN undefined, UD=0 still counts up.

Source files
------------

// File: rtl/my_counter_pkg.sv
// Shared definitions for the my_counter_n modulo-N up/down counter.
// Holds the direction encoding carried on the UD pin, the operation
// selector used by the next-state logic, and the parameter legality check
// evaluated when the counter is elaborated.
package my_counter_pkg;

  // Encoding of the UD pin: high selects up-counting, low selects down-counting.
  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Operation chosen for the next rising clock edge once reset has been ruled out.
  typedef enum logic [1:0] {
    OP_HOLD  = 2'd0,
    OP_COUNT = 2'd1,
    OP_LOAD  = 2'd2
  } count_op_e;

  // True when the width/modulus pair describes a counter that can be built:
  // width between 2 and 16 bits, and a modulus between 2 and 2**width.
  function automatic bit modulusLegal(input int width, input int modulus);
    bit widthOk;
    bit modulusOk;
    widthOk   = (width >= 2) && (width <= 16);
    modulusOk = widthOk && (modulus >= 2) && (modulus <= (1 << width));
    return modulusOk;
  endfunction

endpackage

// File: rtl/my_counter_tc.sv
// Terminal-count decode for my_counter_n.
// Given the present count, the requested direction and the trickle enable,
// it produces the effective direction, the wrap flag used by the next-state
// logic, and the cascade carry CO.
// Macro MY_COUNTER_DOWN_EN: when defined, UD selects up or down counting;
// when undefined, the counter is up-only and UD is ignored.
module my_counter_tc
  import my_counter_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16
) (
  input  logic [WIDTH-1:0] q_i,
  input  logic             ud_i,
  input  logic             ctt_i,
  output logic             dirUp_o,
  output logic             wrap_o,
  output logic             co_o
);

  localparam logic [WIDTH-1:0] TERM      = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   TERM_WIDE = (WIDTH + 1)'(MODULUS - 1);

  logic atTerm;
  logic atZero;
  logic atOrAboveTerm;
  logic aboveTerm;

`ifdef MY_COUNTER_DOWN_EN
  // The UD pin directly picks the direction; nothing about it is remembered between edges.
  always_comb begin
    dirUp_o = (ud_i == DIR_UP);
  end
`else
  logic unusedUd;

  // Up-only build: the direction is fixed and UD is only tied off so it stays visibly consumed.
  always_comb begin
    unusedUd = ud_i;
    dirUp_o  = DIR_UP;
  end
`endif

  // Compare against the last legal count; the one-bit-wider compare keeps the
  // out-of-range test meaningful even when the modulus fills the whole width.
  always_comb begin
    atTerm        = (q_i == TERM);
    atZero        = (q_i == '0);
    atOrAboveTerm = ({1'b0, q_i} >= TERM_WIDE);
    aboveTerm     = ({1'b0, q_i} > TERM_WIDE);
  end

  // Up wraps from the last legal value or anything loaded beyond it; down wraps
  // from zero or from an out-of-range loaded value back to the last legal value.
  // The carry is gated only by the trickle enable so it can feed the next stage.
  always_comb begin
    wrap_o = 1'b0;
    co_o   = 1'b0;
    if (dirUp_o == DIR_DOWN) begin
      wrap_o = atZero || aboveTerm;
      co_o   = ctt_i && atZero;
    end else begin
      wrap_o = atOrAboveTerm;
      co_o   = ctt_i && atTerm;
    end
  end

endmodule

// File: rtl/my_counter_n.sv
// my_counter_n: synchronous, loadable, cascadable modulo-MODULUS counter.
// Rising edge of CP updates the count with priority reset (CR) over
// parallel load (LDbar low) over count (CTP and CTT high) over hold.
// CO is a combinational terminal-count carry intended to drive the CTT of
// the next, more significant stage.
// Macro MY_COUNTER_DOWN_EN: when defined, UD selects up (1) or down (0)
// counting; when undefined the counter only counts up and UD is ignored.
module my_counter_n
  import my_counter_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16
) (
  input  logic             CP,
  input  logic             CR,
  input  logic             LDbar,
  input  logic             CTP,
  input  logic             CTT,
  input  logic             UD,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             CO
);

  localparam logic [WIDTH-1:0] TERM = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  if (!modulusLegal(WIDTH, MODULUS)) begin : gBadParams
    $error("my_counter_n: WIDTH must be 2..16 and MODULUS must be 2..2**WIDTH");
  end

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  count_op_e        countOp;
  logic             dirUp;
  logic             wrap;
  logic             carry;

  my_counter_tc #(
    .WIDTH   (WIDTH),
    .MODULUS (MODULUS)
  ) u_tc (
    .q_i     (count_q),
    .ud_i    (UD),
    .ctt_i   (CTT),
    .dirUp_o (dirUp),
    .wrap_o  (wrap),
    .co_o    (carry)
  );

  // Pick what the next edge does when reset is not asserted: load wins over count,
  // and counting needs both the parallel and the trickle enable.
  always_comb begin
    countOp = OP_HOLD;
    if (!LDbar) begin
      countOp = OP_LOAD;
    end else if (CTP && CTT) begin
      countOp = OP_COUNT;
    end
  end

  // Form the next count; loaded data is taken verbatim, even beyond the modulus,
  // and the wrap flag from the decoder decides when a step folds around.
  always_comb begin
    count_d = count_q;
    case (countOp)
      OP_LOAD: begin
        count_d = D;
      end
      OP_COUNT: begin
        if (dirUp) begin
          count_d = wrap ? '0 : count_q + ONE;
        end else begin
          count_d = wrap ? TERM : count_q - ONE;
        end
      end
      default: begin
        count_d = count_q;
      end
    endcase
  end

  // Count register with synchronous reset that overrides any load or count on the same edge.
  always_ff @(posedge CP) begin
    if (CR) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // The count and its carry leave the block with no extra pipeline stage.
  always_comb begin
    Q  = count_q;
    CO = carry;
  end

endmodule
